bmc_pipe: RTL and testbench

BMC_PIPE -- requirements
Module: bmc_pipe

---
 rtl/bmc_pipe.sv | 103 ++++++++++
 tb/tb_bmc_pipe.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmc_pipe.sv
// bmc_pipe: branch metrics for a rate-1/2 Viterbi decoder, one registered
// output stage with valid/ready handshake and in-frame symbol position.
module bmc_pipe #(
  parameter int K = 3,
  parameter int SOFT_W = 1,
  parameter logic [(2**K)-1:0] INV_MASK = 8'b0110_0110,
  parameter int FRAME_LEN = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SOFT_W-1:0]             in_sym0,
  input  logic [SOFT_W-1:0]             in_sym1,
  input  logic [1:0]                    in_punct,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [(2**K)*(SOFT_W+1)-1:0]  out_bm0,
  output logic [(2**K)*(SOFT_W+1)-1:0]  out_bm1,
  output logic                          out_last,
  output logic [$clog2(FRAME_LEN)-1:0]  sym_idx
);

  localparam int N_BMC = 2**K;
  localparam int MW = SOFT_W + 1;
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [MW-1:0] SMAX = MW'((2**SOFT_W) - 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  localparam int BW = N_BMC * MW;

  logic          vld_q, vld_d;
  logic [BW-1:0] bm0_q, bm0_d;
  logic [BW-1:0] bm1_q, bm1_d;
  logic          last_q, last_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] fcnt_q, fcnt_d;

  logic          in_xfer, out_xfer;
  logic [MW-1:0] a0, a1, b0, b1;
  logic [BW-1:0] m0, m1;

  assign in_ready = rst_n & (~vld_q | out_ready);
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = vld_q & out_ready;

  // a*: distance to expected 0, b*: distance to expected 1; erasures cost 0
  always_comb begin
    a0 = in_punct[0] ? '0 : {1'b0, in_sym0};
    b0 = in_punct[0] ? '0 : SMAX - {1'b0, in_sym0};
    a1 = in_punct[1] ? '0 : {1'b0, in_sym1};
    b1 = in_punct[1] ? '0 : SMAX - {1'b0, in_sym1};
    m0 = '0;
    m1 = '0;
    for (int i = 0; i < N_BMC; i++) begin
      m0[i*MW +: MW] = a0 + (INV_MASK[i] ? b1 : a1);
      m1[i*MW +: MW] = b0 + (INV_MASK[i] ? a1 : b1);
    end
  end

  always_comb begin
    vld_d  = vld_q;
    bm0_d  = bm0_q;
    bm1_d  = bm1_q;
    last_d = last_q;
    idx_d  = idx_q;
    fcnt_d = fcnt_q;
    if (in_xfer) begin
      vld_d  = 1'b1;
      bm0_d  = m0;
      bm1_d  = m1;
      idx_d  = fcnt_q;
      last_d = (fcnt_q == LAST);
      fcnt_d = (fcnt_q == LAST) ? '0 : fcnt_q + CW'(1);
    end else if (out_xfer) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      bm0_q  <= '0;
      bm1_q  <= '0;
      last_q <= 1'b0;
      idx_q  <= '0;
      fcnt_q <= '0;
    end else begin
      vld_q  <= vld_d;
      bm0_q  <= bm0_d;
      bm1_q  <= bm1_d;
      last_q <= last_d;
      idx_q  <= idx_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign out_valid = vld_q;
  assign out_bm0   = bm0_q;
  assign out_bm1   = bm1_q;
  assign out_last  = last_q;
  assign sym_idx   = idx_q;

endmodule

// File: tb/tb_bmc_pipe.sv
// tb_bmc_pipe: hard-decision and soft (3-bit, 4-pair frame) instances run in
// lockstep against a queue-based reference model plus directed checks.
module tb_bmc_pipe;

  logic        clk, rst_n;
  logic        in_valid, out_ready;
  logic [1:0]  in_punct;
  logic        hs0, hs1;
  logic [2:0]  ss0, ss1;

  logic        h_ir, h_ov, h_last;
  logic [15:0] h_bm0, h_bm1;
  logic [3:0]  h_idx;
  logic        s_ir, s_ov, s_last;
  logic [31:0] s_bm0, s_bm1;
  logic [1:0]  s_idx;

  int n_chk = 0;
  int n_fail = 0;
  int n_out = 0;
  int fh = 0;
  int fs = 0;

  typedef struct {
    logic [15:0] hb0, hb1;
    logic        hl;
    logic [3:0]  hi;
    logic [31:0] sb0, sb1;
    logic        sl;
    logic [1:0]  si;
  } exp_t;
  exp_t q[$];

  bmc_pipe u_hard (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(h_ir),
    .in_sym0(hs0), .in_sym1(hs1), .in_punct(in_punct),
    .out_valid(h_ov), .out_ready(out_ready),
    .out_bm0(h_bm0), .out_bm1(h_bm1),
    .out_last(h_last), .sym_idx(h_idx)
  );

  bmc_pipe #(.SOFT_W(3), .FRAME_LEN(4)) u_soft (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_ir),
    .in_sym0(ss0), .in_sym1(ss1), .in_punct(in_punct),
    .out_valid(s_ov), .out_ready(out_ready),
    .out_bm0(s_bm0), .out_bm1(s_bm1),
    .out_last(s_last), .sym_idx(s_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Metric = sum over both code bits of distance to the branch's expected bit
  function automatic logic [63:0] ref_bm(int sw, int r0, int r1,
                                         logic [1:0] p, int path);
    int smax, mw, e0, e1, d0, d1;
    logic [63:0] v;
    smax = (1 << sw) - 1;
    mw = sw + 1;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      e0 = path;
      e1 = ((8'h66 >> i) & 1) ^ path;
      d0 = p[0] ? 0 : (e0 == 1 ? smax - r0 : r0);
      d1 = p[1] ? 0 : (e1 == 1 ? smax - r1 : r1);
      v = v | (64'(d0 + d1) << (i * mw));
    end
    return v;
  endfunction

  always @(negedge clk) begin
    bit rdy;
    exp_t e;
    rdy = rst_n && (q.size() == 0 || out_ready);
    chk("h_in_ready", h_ir, rdy);
    chk("s_in_ready", s_ir, rdy);
    chk("h_out_valid", h_ov, q.size() != 0);
    chk("s_out_valid", s_ov, q.size() != 0);
    if (q.size() != 0) begin
      chk("h_bm0", h_bm0, q[0].hb0);
      chk("h_bm1", h_bm1, q[0].hb1);
      chk("h_last", h_last, q[0].hl);
      chk("h_idx", h_idx, q[0].hi);
      chk("s_bm0", s_bm0, q[0].sb0);
      chk("s_bm1", s_bm1, q[0].sb1);
      chk("s_last", s_last, q[0].sl);
      chk("s_idx", s_idx, q[0].si);
      if (out_ready) begin
        void'(q.pop_front());
        n_out++;
      end
    end
    if (rdy && in_valid) begin
      e.hb0 = 16'(ref_bm(1, hs0, hs1, in_punct, 0));
      e.hb1 = 16'(ref_bm(1, hs0, hs1, in_punct, 1));
      e.hi  = 4'(fh);
      e.hl  = (fh == 15);
      e.sb0 = 32'(ref_bm(3, ss0, ss1, in_punct, 0));
      e.sb1 = 32'(ref_bm(3, ss0, ss1, in_punct, 1));
      e.si  = 2'(fs);
      e.sl  = (fs == 3);
      q.push_back(e);
      fh = (fh + 1) % 16;
      fs = (fs + 1) % 4;
    end
    if (!rst_n) begin
      q.delete();
      fh = 0;
      fs = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_data();
    hs0 = 1'($urandom);
    hs1 = 1'($urandom);
    ss0 = 3'($urandom);
    ss1 = 3'($urandom);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int t0[4] = '{0, 1, 1, 2};
    int t1[4] = '{2, 1, 1, 0};
    int n0;
    logic [63:0] ra;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_punct = 2'b00;
    hs0 = 1'b0; hs1 = 1'b0;
    ss0 = 3'd0; ss1 = 3'd0;
    step();
    step();
    chk("rst_in_ready", h_ir, 0);
    chk("rst_h_valid", h_ov, 0);
    chk("rst_h_bm0", h_bm0, 0);
    chk("rst_h_bm1", h_bm1, 0);
    chk("rst_h_idx", h_idx, 0);
    chk("rst_h_last", h_last, 0);
    chk("rst_s_valid", s_ov, 0);
    chk("rst_s_bm0", s_bm0, 0);
    rst_n = 1'b1;

    // hard sweep + soft directed values
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      hs0 = k[0]; hs1 = k[1];
      ss0 = 3'd5; ss1 = 3'd2;
      in_valid = 1'b1;
      step();
      chk("sweep_u0_bm0", h_bm0[1:0], t0[k]);
      chk("sweep_u0_bm1", h_bm1[1:0], t1[k]);
      if (k == 2) begin
        chk("sweep_u1_bm0", h_bm0[3:2], 0);
        chk("sweep_u1_bm1", h_bm1[3:2], 2);
      end
      chk("soft_u0_bm0", s_bm0[3:0], 7);
      chk("soft_u0_bm1", s_bm1[3:0], 7);
      chk("soft_u1_bm0", s_bm0[7:4], 10);
      chk("soft_u1_bm1", s_bm1[7:4], 4);
    end
    in_punct = 2'b01;
    step();
    chk("punct_u0_bm0", s_bm0[3:0], 2);
    chk("punct_u0_bm1", s_bm1[3:0], 5);
    in_punct = 2'b00;
    in_valid = 1'b0;
    step();

    // frame wrap on the 4-pair instance
    pulse_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      rnd_data();
      step();
      chk("wrap_idx", s_idx, k % 4);
      chk("wrap_last", s_last, (k % 4) == 3);
    end
    in_valid = 1'b0;
    step();

    // backpressure
    pulse_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    ss0 = 3'd6; ss1 = 3'd1;
    ra = ref_bm(3, 6, 1, 2'b00, 0);
    step();
    ss0 = 3'd0; ss1 = 3'd7;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_in_ready", s_ir, 0);
      chk("bp_idx", s_idx, 0);
      chk("bp_bm0", s_bm0, ra);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("bp_new_valid", s_ov, 1);
    chk("bp_new_idx", s_idx, 1);
    chk("bp_new_bm0", s_bm0, ref_bm(3, 0, 7, 2'b00, 0));
    step();
    chk("bp_still_held", s_idx, 1);
    out_ready = 1'b1;
    step();
    chk("bp_drained", s_ov, 0);

    // reset during a stall
    pulse_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rnd_data();
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rs_idx_before", s_idx, 2);
    step();
    chk("rs_stalled", s_ov, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rs_s_valid", s_ov, 0);
    chk("rs_h_valid", h_ov, 0);
    out_ready = 1'b1;
    in_valid = 1'b1;
    rnd_data();
    step();
    in_valid = 1'b0;
    chk("rs_s_idx0", s_idx, 0);
    chk("rs_h_idx0", h_idx, 0);
    step();

    // full throughput
    n0 = n_out;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      rnd_data();
      in_punct = 2'($urandom);
      step();
      chk("tput_valid", s_ov, 1);
    end
    in_valid = 1'b0;
    in_punct = 2'b00;
    step();
    step();
    chk("tput_count", n_out - n0, 100);

    // random handshakes
    for (int k = 0; k < 300; k++) begin
      rnd_data();
      in_punct = 2'($urandom);
      in_valid = 1'($urandom);
      out_ready = 1'($urandom);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() != 0; k++) step();
    step();
    chk("drain_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
